// File: rtl/door_actuator_model.sv
// Behavioural plant model of a motorised door: turns open/close drive commands into
// travel with a prescaled step rate and returns the limit-switch view of position.
module door_actuator_model #(
  parameter int unsigned TRAVEL   = 100,
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       motor_open,
  input  logic       motor_close,
  input  logic       obstruct,
  output logic       lim_open,
  output logic       lim_closed,
  output logic [7:0] pos,
  output logic       moving,
  output logic       fault,
  output logic [7:0] close_count
);

  typedef enum logic [2:0] {StClosed, StOpening, StOpen, StClosing, StFault} state_e;

  localparam logic [7:0] PosMax = 8'(TRAVEL);
  localparam logic [7:0] PreMax = 8'(PRESCALE - 1);

  state_e     state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] cnt_q, cnt_d;
  logic       run_q, run_d;
  logic       open_only, close_only, step;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    run_d      = 1'b0;
    open_only  = motor_open & ~motor_close;
    close_only = motor_close & ~motor_open;
    step       = (pre_q == PreMax);

    if (motor_open && motor_close) begin
      state_d = StFault;
      pre_d   = '0;
    end else if (open_only) begin
      if (pos_q == PosMax) begin
        state_d = StOpen;
        pre_d   = '0;
      end else if (state_q == StClosing) begin
        // Reversal cycle: restart the step timer, no step this edge.
        state_d = StOpening;
        pre_d   = '0;
        run_d   = 1'b1;
      end else if (step) begin
        pre_d = '0;
        pos_d = pos_q + 8'd1;
        if (pos_q == PosMax - 8'd1) begin
          state_d = StOpen;
        end else begin
          state_d = StOpening;
          run_d   = 1'b1;
        end
      end else begin
        state_d = StOpening;
        pre_d   = pre_q + 8'd1;
        run_d   = 1'b1;
      end
    end else if (close_only) begin
      if (pos_q == '0) begin
        state_d = StClosed;
        pre_d   = '0;
      end else if (state_q == StOpening) begin
        state_d = StClosing;
        pre_d   = '0;
        run_d   = ~obstruct;
      end else if (obstruct) begin
        // Blocked doorway: hold position with the step timer parked at zero.
        state_d = StClosing;
        pre_d   = '0;
      end else if (step) begin
        pre_d = '0;
        pos_d = pos_q - 8'd1;
        if (pos_q == 8'd1) begin
          state_d = StClosed;
          if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        end else begin
          state_d = StClosing;
          run_d   = 1'b1;
        end
      end else begin
        state_d = StClosing;
        pre_d   = pre_q + 8'd1;
        run_d   = 1'b1;
      end
    end else begin
      pre_d = '0;
      if (state_q == StFault) begin
        // A mid-travel fault release parks as a stopped opening.
        if (pos_q == '0)         state_d = StClosed;
        else if (pos_q == PosMax) state_d = StOpen;
        else                      state_d = StOpening;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClosed;
      pos_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      pos_q   <= pos_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  assign lim_open    = (pos_q == PosMax);
  assign lim_closed  = (pos_q == '0);
  assign pos         = pos_q;
  assign moving      = run_q;
  assign fault       = (state_q == StFault);
  assign close_count = cnt_q;

endmodule
